// File: rtl/red_ctrl_pkg.sv
// Shared types and step constants for the multi-cycle RED sequencer.
// The step indices select the adder operands and the result slice written at each step.
package red_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         RED_STEPS = 7;
  localparam logic [2:0] STEP_LAST = 3'(RED_STEPS - 1);

  localparam logic [2:0] STEP_S0_LO  = 3'd0;
  localparam logic [2:0] STEP_S0_HI  = 3'd1;
  localparam logic [2:0] STEP_S1_LO  = 3'd2;
  localparam logic [2:0] STEP_S1_HI  = 3'd3;
  localparam logic [2:0] STEP_F_LO   = 3'd4;
  localparam logic [2:0] STEP_F_HI   = 3'd5;
  localparam logic [2:0] STEP_F_SIGN = 3'd6;

endpackage

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder: sum = a + b + cin, with carry out and signed overflow.
module cla_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovfl
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
    ovfl = c[4] ^ c[3];
  end

endmodule

// File: rtl/red_seq_ctrl.sv
// RED reduction sequencer: one shared 4-bit adder stepped seven times per request,
// result is sign-extended bit 8 of ((a_lo + b_lo) + (a_hi + b_hi)).
//
// state | meaning
// IDLE  | req_ready high, waiting for an operand pair
// BUSY  | running adder steps 0..6, one per cycle
// DONE  | rsp_valid high, result held until rsp_ready
module red_seq_ctrl
  import red_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic             c_q, c_d;
  logic [8:0]       s0_q, s0_d;
  logic [8:0]       s1_q, s1_d;
  logic [8:0]       f_q, f_d;  // f[9] is never needed, so it is not stored
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic [3:0] add_x, add_y, add_sum;
  logic       add_cin, add_cout;

  cla_adder_4bit u_adder (
    .a    (add_x),
    .b    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovfl ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= 3'd0;
      c_q        <= 1'b0;
      s0_q       <= 9'd0;
      s1_q       <= 9'd0;
      f_q        <= 9'd0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      tag_q      <= '0;
      rsp_data_q <= 16'd0;
      rsp_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      c_q        <= c_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      f_q        <= f_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!flush && req_valid) state_d = BUSY;
      BUSY: begin
        if (flush)                    state_d = IDLE;
        else if (step_q == STEP_LAST) state_d = DONE;
      end
      DONE: if (flush || rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    rsp_data  = rsp_data_q;
    rsp_tag   = rsp_tag_q;
  end

  always_comb begin
    add_x   = 4'd0;
    add_y   = 4'd0;
    add_cin = 1'b0;
    case (step_q)
      STEP_S0_LO:  begin add_x = a_q[3:0];   add_y = b_q[3:0];                 end
      STEP_S0_HI:  begin add_x = a_q[7:4];   add_y = b_q[7:4];   add_cin = c_q; end
      STEP_S1_LO:  begin add_x = a_q[11:8];  add_y = b_q[11:8];                end
      STEP_S1_HI:  begin add_x = a_q[15:12]; add_y = b_q[15:12]; add_cin = c_q; end
      STEP_F_LO:   begin add_x = s0_q[3:0];  add_y = s1_q[3:0];                end
      STEP_F_HI:   begin add_x = s0_q[7:4];  add_y = s1_q[7:4];  add_cin = c_q; end
      STEP_F_SIGN: begin
        add_x   = {3'b000, s0_q[8]};
        add_y   = {3'b000, s1_q[8]};
        add_cin = c_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    step_d     = step_q;
    c_d        = c_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    f_d        = f_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;

    if (flush) begin
      step_d = 3'd0;
      c_d    = 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      a_d    = req_a;
      b_d    = req_b;
      tag_d  = req_tag;
      step_d = 3'd0;
      c_d    = 1'b0;
    end else if (state_q == BUSY) begin
      if (step_q != STEP_LAST) step_d = step_q + 3'd1;
      case (step_q)
        STEP_S0_LO:  begin s0_d[3:0] = add_sum; c_d = add_cout; end
        STEP_S0_HI:  s0_d[8:4] = {add_cout, add_sum};
        STEP_S1_LO:  begin s1_d[3:0] = add_sum; c_d = add_cout; end
        STEP_S1_HI:  s1_d[8:4] = {add_cout, add_sum};
        STEP_F_LO:   begin f_d[3:0] = add_sum; c_d = add_cout; end
        STEP_F_HI:   begin f_d[7:4] = add_sum; c_d = add_cout; end
        STEP_F_SIGN: begin
          f_d[8]     = add_sum[0];
          rsp_data_d = {{7{add_sum[0]}}, add_sum[0], f_q[7:0]};
          rsp_tag_d  = tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Randomized scoreboard bench for red_seq_ctrl: expected results come from an
// arithmetic reference of the reduction and are popped by a response monitor.
module tb_red_seq_ctrl;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  red_seq_ctrl #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]      d;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] red_ref(input logic [15:0] a, input logic [15:0] b);
    int         s0, s1;
    logic [8:0] low;
    s0  = int'(a[7:0]) + int'(b[7:0]);
    s1  = int'(a[15:8]) + int'(b[15:8]);
    low = 9'(s0 + s1);
    return {{7{low[8]}}, low};
  endfunction

  always begin : monitor
    exp_t e;
    @(negedge clk);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.d));
        check("rsp_tag", 32'(rsp_tag), 32'(e.t));
      end
    end
  end

  // Present a request and return once accepted (caller is at accept edge + 1).
  task automatic accept(input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] tag, output int acc_cyc);
    int n = 0;
    req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    sb.push_back('{red_ref(a, b), tag});
    req_valid = 1'b0;
    req_a = 16'($urandom);
    req_b = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag, input int hold, output int acc_cyc);
    int          k = 0;
    logic [15:0] exp_d;
    exp_d = red_ref(a, b);
    accept(a, b, tag, acc_cyc);
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("latency", 32'(k), 32'd7);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      req_tag   = TAG_W'($urandom);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(exp_d));
      check("hold_tag", 32'(rsp_tag), 32'(tag));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag_s);
    check({tag_s, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag_s, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag_s, "_busy"}, 32'(busy), 32'd0);
    check({tag_s, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag_s, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int acc, prev;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 16'd0; req_b = 16'd0; req_tag = '0;
    #12;
    check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    send(16'h0102, 16'h0304, 4'h5, 0, acc);
    send(16'hFFFF, 16'hFFFF, 4'hA, 0, acc);
    send(16'h7F7F, 16'h0101, 4'h3, 0, acc);
    send(16'h8080, 16'h8080, 4'hC, 0, acc);
    send(16'h1234, 16'h4321, 4'h9, 5, acc);

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; req_a = 16'h1111; req_b = 16'h2222; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'd0);
    check("idle_flush_ready", 32'(req_ready), 32'd1);

    // Flush during step 3.
    accept(16'hFFFF, 16'hFFFF, 4'h7, acc);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sb.pop_back());
    check("flush_req_ready", 32'(req_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("flush_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    send(16'h0001, 16'h0001, 4'h2, 0, acc);

    // Asynchronous reset during step 5.
    accept(16'hABCD, 16'h1357, 4'hE, acc);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    #1 rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;

    // Back-to-back requests, each answered immediately.
    send(16'($urandom), 16'($urandom), TAG_W'($urandom), 0, prev);
    for (int i = 0; i < 3; i++) begin
      send(16'($urandom), 16'($urandom), TAG_W'($urandom), 0, acc);
      check("accept_spacing", 32'(acc - prev), 32'd9);
      prev = acc;
    end

    // Randomized traffic with random response back-pressure.
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), 16'($urandom), TAG_W'($urandom), int'($urandom_range(0, 3)), acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/red_seq_ctrl.md
# red_seq_ctrl

Multi-cycle sequencer for the RED (reduction) instruction. It time-multiplexes a single 4-bit carry-lookahead adder over seven steps and produces the same 16-bit result as the combinational reduction unit, trading latency for area. It sits beside the ALU in the execute stage. It accepts one operand pair per transaction over a valid/ready request channel and returns the result, with a tag, over a valid/ready response channel. RED never modifies flags; this block has no flag outputs.

## Interface
- TAG_W, default 4: width of the opaque tag carried from request to response.

- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- flush  in  1  synchronous abort; drops any in-flight or pending transaction.
- req_valid  in  1  request operands valid.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_a  in  16  operand a (rs).
- req_b  in  16  operand b (rt).
- req_tag  in  TAG_W  request tag.
- rsp_valid  out  1  result valid; held until accepted.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  16  reduction result.
- rsp_tag  out  TAG_W  tag of the accepted request.
- busy  out  1  high in BUSY or DONE.

## Operation
- Result definition:
  - s0 = a[7:0] + b[7:0], 9 bits.
  - s1 = a[15:8] + b[15:8], 9 bits.
  - f = s0 + s1, 10 bits.
  - rsp_data = {7{f[8]}, f[8:0]}. f[9] is discarded.
- States:
  - IDLE: req_ready = 1. On req_valid, latch a, b and tag, set step = 0, go to BUSY.
  - BUSY: perform one adder step per cycle, steps 0–6. After step 6, go to DONE.
  - DONE: rsp_valid = 1. On rsp_ready, go to IDLE.
- Step schedule, one adder (x + y + cin), with a 1-bit carry register c:
  - 0: a[3:0] + b[3:0], cin = 0 → s0[3:0], c.
  - 1: a[7:4] + b[7:4] + c → s0[7:4], s0[8] = cout.
  - 2: a[11:8] + b[11:8], cin = 0 → s1[3:0], c.
  - 3: a[15:12] + b[15:12] + c → s1[7:4], s1[8] = cout.
  - 4: s0[3:0] + s1[3:0], cin = 0 → f[3:0], c.
  - 5: s0[7:4] + s1[7:4] + c → f[7:4], c.
  - 6: {3'b0, s0[8]} + {3'b0, s1[8]} + c → f[8] = adder_out[0]. rsp_data is registered at this edge.
- Operands are latched only in IDLE. req_a and req_b may change after acceptance without effect.
- A new request is accepted only in IDLE. There is no overlap with an in-flight transaction.
- Flush:
  - In any state, flush returns the block to IDLE at the next edge.
  - rsp_valid drops and the result is lost.
  - flush takes priority over both req and rsp handshakes in the same cycle.
  - In IDLE, flush also blocks acceptance that cycle.
- Asynchronous reset mid-operation aborts immediately; no response is produced.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, busy = 0.
  - rsp_data = 16'h0000, rsp_tag = 0.
  - Internal c, s0, s1, f and step = 0.
- Acceptance edge E0 is the edge where req_valid && req_ready.
- Steps 0–6 complete at edges E1–E7.
- rsp_valid is high from the cycle after E7, i.e. 7 cycles after acceptance.
- Response handshake at edge E8 at the earliest. req_ready is high in the following cycle.
- Minimum spacing between acceptances is 9 cycles.
- rsp_data and rsp_tag are stable while rsp_valid && !rsp_ready.
- req_ready and rsp_valid are decoded from registered state only; there is no combinational path from input to output.
- Step counter: 3 bits, counts 0–6 in BUSY. It never wraps; the exit to DONE is decoded at step == 6.

## Structure
- Package red_ctrl_pkg:
  - state enum {IDLE, BUSY, DONE};
  - RED_STEPS = 7 and STEP_LAST = 3'd6;
  - the step-index constants used by the operand mux.
- One sub-module: a single instance of the existing cla_adder_4bit, with its ovfl output left unconnected.
- The operand/carry-in mux and the result-slice write enables are decoded from step.

## Test plan
- a=16'h0102, b=16'h0304 → rsp_data=16'h000A, rsp_tag echoed; rsp_valid first high exactly 7 cycles after the accept edge.
- a=16'hFFFF, b=16'hFFFF → f=10'h3FC, rsp_data=16'hFFFC. Also a=16'h7F7F, b=16'h0101 → 16'hFF00 (sign extension of f[8]).
- a=16'h8080, b=16'h8080 → f=10'h200, f[9] discarded, rsp_data=16'h0000.
- rsp_ready held low 5 cycles in DONE, with req_valid held high and new operands driven → rsp_data/tag stable, req_ready=0, nothing accepted; after the handshake, req_ready=1 next cycle.
- flush asserted during step 3 → rsp_valid never rises, IDLE next cycle. Then a=16'h0001, b=16'h0001 → 16'h0002, with no carry leakage from the aborted run.
- rst_n pulsed low during step 5 → all outputs at reset values immediately. Then back-to-back requests, each followed by rsp_ready=1 → accepts spaced exactly 9 cycles apart.
